// File: rtl/dac_delay_pkg.sv
// Shared types and constants for the DAC ODELAY stepping logic.
package dac_delay_pkg;

  localparam int unsigned TAP_W   = 6;
  localparam int unsigned MAX_TAP = 63;
  localparam int unsigned GAP_W   = 4;

  typedef logic [TAP_W-1:0] tap_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/odelay_tap_tracker.sv
// Tracks target and current tap for one ODELAY line; steps the tap by one on request.
module odelay_tap_tracker #(
  parameter int unsigned TAP_W = 6
) (
  input  logic             clk40,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [TAP_W-1:0] load_target,
  input  logic             step_en,
  output logic [TAP_W-1:0] tap,
  output logic             differ_c,
  output logic             inc_c
);

  logic [TAP_W-1:0] target_q, target_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] eff_target_c;

  // A load in the same cycle as a step decision retargets that step immediately.
  always_comb begin
    eff_target_c = load ? load_target : target_q;
    differ_c     = (eff_target_c != tap_q);
    inc_c        = (eff_target_c > tap_q);
  end

  always_comb begin
    target_d = target_q;
    tap_d    = tap_q;
    if (clear) begin
      target_d = '0;
      tap_d    = '0;
    end else begin
      if (load) begin
        target_d = load_target;
      end
      if (step_en) begin
        tap_d = inc_c ? (tap_q + TAP_W'(1)) : (tap_q - TAP_W'(1));
      end
    end
  end

  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      tap_q    <= '0;
    end else begin
      target_q <= target_d;
      tap_q    <= tap_d;
    end
  end

  assign tap = tap_q;

endmodule

// File: rtl/dac_odelay_stepper.sv
// Walks the DAC clock and data ODELAY lines to absolute tap targets with paced CE/INC pulses.
module dac_odelay_stepper #(
  parameter int unsigned TAP_W    = dac_delay_pkg::TAP_W,
  parameter int unsigned MAX_TAP  = dac_delay_pkg::MAX_TAP,
  parameter int unsigned STEP_GAP = 2
) (
  input  logic             clk40,
  input  logic             rst,
  input  logic             tap_reset,
  input  logic             load_strb,
  input  logic [TAP_W-1:0] clk_target,
  input  logic [TAP_W-1:0] data_target,
  output logic             clk_ce,
  output logic             clk_inc,
  output logic             data_ce,
  output logic             data_inc,
  output logic [TAP_W-1:0] clk_tap,
  output logic [TAP_W-1:0] data_tap,
  output logic             busy,
  output logic             done_strb,
  output logic             saturated
);

  import dac_delay_pkg::*;

  // A zero gap still leaves one idle cycle so CE never fires back-to-back.
  localparam int unsigned GAP_LEN            = (STEP_GAP == 0) ? 1 : STEP_GAP;
  localparam logic [GAP_W-1:0] GAP_RELOAD    = GAP_W'(GAP_LEN - 1);
  localparam logic [TAP_W:0]   MAX_TAP_WIDE  = (TAP_W+1)'(MAX_TAP);
  localparam logic [TAP_W-1:0] MAX_TAP_V     = TAP_W'(MAX_TAP);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             clk_ce_q, clk_ce_d;
  logic             clk_inc_q, clk_inc_d;
  logic             data_ce_q, data_ce_d;
  logic             data_inc_q, data_inc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;

  logic             clk_over_c, data_over_c;
  logic [TAP_W-1:0] clk_clamp_c, data_clamp_c;
  logic             load_ok_c;
  logic             clk_step_c, data_step_c;
  logic             clk_differ_c, data_differ_c;
  logic             clk_up_c, data_up_c;

  // Clamp incoming targets; compare one bit wider so a full-range MAX_TAP stays well defined.
  always_comb begin
    clk_over_c   = ({1'b0, clk_target}  > MAX_TAP_WIDE);
    data_over_c  = ({1'b0, data_target} > MAX_TAP_WIDE);
    clk_clamp_c  = clk_over_c  ? MAX_TAP_V : clk_target;
    data_clamp_c = data_over_c ? MAX_TAP_V : data_target;
    load_ok_c    = load_strb & ~tap_reset;
  end

  odelay_tap_tracker #(
    .TAP_W (TAP_W)
  ) u_clk_trk (
    .clk40       (clk40),
    .rst         (rst),
    .clear       (tap_reset),
    .load        (load_ok_c),
    .load_target (clk_clamp_c),
    .step_en     (clk_step_c),
    .tap         (clk_tap),
    .differ_c    (clk_differ_c),
    .inc_c       (clk_up_c)
  );

  odelay_tap_tracker #(
    .TAP_W (TAP_W)
  ) u_data_trk (
    .clk40       (clk40),
    .rst         (rst),
    .clear       (tap_reset),
    .load        (load_ok_c),
    .load_target (data_clamp_c),
    .step_en     (data_step_c),
    .tap         (data_tap),
    .differ_c    (data_differ_c),
    .inc_c       (data_up_c)
  );

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    clk_ce_d    = 1'b0;
    clk_inc_d   = 1'b0;
    data_ce_d   = 1'b0;
    data_inc_d  = 1'b0;
    done_d      = 1'b0;
    sat_d       = sat_q;
    clk_step_c  = 1'b0;
    data_step_c = 1'b0;

    if (tap_reset) begin
      state_d   = IDLE;
      gap_cnt_d = '0;
    end else begin
      if (load_strb) begin
        sat_d = clk_over_c | data_over_c;
      end
      unique case (state_q)
        IDLE: begin
          if (load_strb) begin
            state_d = STEP;
          end
        end
        STEP: begin
          if (clk_differ_c | data_differ_c) begin
            clk_step_c  = clk_differ_c;
            data_step_c = data_differ_c;
            clk_ce_d    = clk_differ_c;
            clk_inc_d   = clk_differ_c & clk_up_c;
            data_ce_d   = data_differ_c;
            data_inc_d  = data_differ_c & data_up_c;
            gap_cnt_d   = GAP_RELOAD;
            state_d     = GAP;
          end else if (!load_strb) begin
            // A load landing on the settle slot re-evaluates next cycle instead of finishing.
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_d = STEP;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE) | done_d;
  end

  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      clk_ce_q   <= 1'b0;
      clk_inc_q  <= 1'b0;
      data_ce_q  <= 1'b0;
      data_inc_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      clk_ce_q   <= clk_ce_d;
      clk_inc_q  <= clk_inc_d;
      data_ce_q  <= data_ce_d;
      data_inc_q <= data_inc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  assign clk_ce    = clk_ce_q;
  assign clk_inc   = clk_inc_q;
  assign data_ce   = data_ce_q;
  assign data_inc  = data_inc_q;
  assign busy      = busy_q;
  assign done_strb = done_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_dac_odelay_stepper.sv
// Self-checking bench for dac_odelay_stepper: walk table, hand-written corner sequences, random vs model.
module tb_dac_odelay_stepper;

  localparam int unsigned TW = 7;
  localparam int unsigned MT = 63;
  localparam int unsigned SG = 2;
  localparam int BUDGET = 400;
  localparam int SLOT = int'(SG) + 1;

  logic          clk40 = 1'b0;
  logic          rst, tap_reset, load_strb;
  logic [TW-1:0] clk_target, data_target;
  logic          clk_ce, clk_inc, data_ce, data_inc, busy, done_strb, saturated;
  logic [TW-1:0] clk_tap, data_tap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk40 = ~clk40;

  dac_odelay_stepper #(
    .TAP_W    (TW),
    .MAX_TAP  (MT),
    .STEP_GAP (SG)
  ) dut (
    .clk40       (clk40),
    .rst         (rst),
    .tap_reset   (tap_reset),
    .load_strb   (load_strb),
    .clk_target  (clk_target),
    .data_target (data_target),
    .clk_ce      (clk_ce),
    .clk_inc     (clk_inc),
    .data_ce     (data_ce),
    .data_inc    (data_inc),
    .clk_tap     (clk_tap),
    .data_tap    (data_tap),
    .busy        (busy),
    .done_strb   (done_strb),
    .saturated   (saturated)
  );

  typedef struct {
    int clk_t;  int data_t;  int done_cyc;
    int clk_up; int clk_dn;  int data_up; int data_dn;
    int fin_clk; int fin_data; int sat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int outs_packed();
    return int'({clk_ce, clk_inc, data_ce, data_inc, busy, done_strb, saturated, clk_tap, data_tap});
  endfunction

  // CE on either line must never repeat in consecutive cycles.
  logic prev_clk_ce = 1'b0, prev_data_ce = 1'b0;
  always @(negedge clk40) begin
    if (rst) begin
      prev_clk_ce  = 1'b0;
      prev_data_ce = 1'b0;
    end else begin
      if (clk_ce)  chk("clk_ce_back_to_back", int'(prev_clk_ce), 0);
      if (data_ce) chk("data_ce_back_to_back", int'(prev_data_ce), 0);
      prev_clk_ce  = clk_ce;
      prev_data_ce = data_ce;
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int  cu = 0, cd = 0, du = 0, dd = 0;
    int  done_cyc = -1, first_ce = -1, off_grid = 0;
    int  busy1 = 0, busy_done = 0, sat_done = 0, fc = 0, fd = 0;
    bit  seen = 1'b0;
    int  exp_first;
    @(negedge clk40);
    chk($sformatf("v%0d_busy_before", idx), int'(busy), 0);
    load_strb   = 1'b1;
    clk_target  = TW'(v.clk_t);
    data_target = TW'(v.data_t);
    for (int cyc = 1; cyc <= BUDGET && !seen; cyc++) begin
      @(negedge clk40);
      load_strb = 1'b0;
      if (clk_ce)  begin if (clk_inc)  cu++; else cd++; end
      if (data_ce) begin if (data_inc) du++; else dd++; end
      if (clk_ce || data_ce) begin
        if (first_ce < 0) first_ce = cyc;
        if ((cyc - 2) % SLOT != 0) off_grid++;
      end
      if (cyc == 1) busy1 = int'(busy);
      if (done_strb) begin
        seen = 1'b1; done_cyc = cyc; busy_done = int'(busy);
        sat_done = int'(saturated); fc = int'(clk_tap); fd = int'(data_tap);
      end
    end
    exp_first = (v.clk_up + v.clk_dn + v.data_up + v.data_dn > 0) ? 2 : -1;
    chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.done_cyc);
    chk($sformatf("v%0d_clk_up", idx), cu, v.clk_up);
    chk($sformatf("v%0d_clk_dn", idx), cd, v.clk_dn);
    chk($sformatf("v%0d_data_up", idx), du, v.data_up);
    chk($sformatf("v%0d_data_dn", idx), dd, v.data_dn);
    chk($sformatf("v%0d_first_ce", idx), first_ce, exp_first);
    chk($sformatf("v%0d_off_grid", idx), off_grid, 0);
    chk($sformatf("v%0d_clk_tap", idx), fc, v.fin_clk);
    chk($sformatf("v%0d_data_tap", idx), fd, v.fin_data);
    chk($sformatf("v%0d_saturated", idx), sat_done, v.sat);
    chk($sformatf("v%0d_busy_cyc1", idx), busy1, 1);
    chk($sformatf("v%0d_busy_done", idx), busy_done, 1);
    @(negedge clk40);
    chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
    chk($sformatf("v%0d_done_once", idx), int'(done_strb), 0);
  endtask

  task automatic rand_phase(input int ncyc);
    int tgt_c = 0, tgt_d = 0, tap_c = 0, tap_d = 0, slot_at = 0, sat = 0;
    bit active = 1'b0;
    bit e_cce, e_cinc, e_dce, e_dinc, e_busy, e_done;
    int exp_v, lc, ldv;
    bit ld, tr;
    e_cce = 0; e_cinc = 0; e_dce = 0; e_dinc = 0; e_busy = 0; e_done = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk40);
      exp_v = int'({e_cce, e_cinc, e_dce, e_dinc, e_busy, e_done, sat[0], TW'(tap_c), TW'(tap_d)});
      chk($sformatf("rand_cyc%0d", n), outs_packed(), exp_v);
      tr = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 29) == 0);
      lc  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
      ldv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
      tap_reset = tr; load_strb = ld;
      clk_target = TW'(lc); data_target = TW'(ldv);
      // Slot-schedule reference: outputs expected in cycle n+1 from inputs sampled in cycle n.
      e_cce = 0; e_cinc = 0; e_dce = 0; e_dinc = 0; e_done = 0;
      if (tr) begin
        tgt_c = 0; tgt_d = 0; tap_c = 0; tap_d = 0; active = 1'b0;
      end else begin
        if (ld) begin
          tgt_c = (lc  > int'(MT)) ? int'(MT) : lc;
          tgt_d = (ldv > int'(MT)) ? int'(MT) : ldv;
          sat   = (lc > int'(MT) || ldv > int'(MT)) ? 1 : 0;
          if (!active) begin active = 1'b1; slot_at = n + 2; end
        end
        if (active && slot_at == n + 1) begin
          if (tap_c != tgt_c || tap_d != tgt_d) begin
            if (tap_c != tgt_c) begin
              e_cce = 1; e_cinc = (tgt_c > tap_c); tap_c += e_cinc ? 1 : -1;
            end
            if (tap_d != tgt_d) begin
              e_dce = 1; e_dinc = (tgt_d > tap_d); tap_d += e_dinc ? 1 : -1;
            end
            slot_at = n + 1 + SLOT;
          end else if (ld) begin
            slot_at = n + 2;
          end else begin
            e_done = 1; active = 1'b0;
          end
        end
      end
      e_busy = active || e_done;
    end
    @(negedge clk40);
    tap_reset = 1'b0; load_strb = 1'b0;
  endtask

  initial begin
    int c4, cnt_dn, cnt_up, dones, done_at, busy_lo, ce_cnt;
    bit hit;
    rst = 1'b1; tap_reset = 1'b0; load_strb = 1'b0;
    clk_target = '0; data_target = '0;

    vecs[0] = '{3,   3,  11,  3,  0,  3,  0,  3,  3, 0};
    vecs[1] = '{10,  10, 23,  7,  0,  7,  0, 10, 10, 0};
    vecs[2] = '{8,   12,  8,  0,  2,  2,  0,  8, 12, 0};
    vecs[3] = '{8,   12,  2,  0,  0,  0,  0,  8, 12, 0};
    vecs[4] = '{70,  5, 167, 55,  0,  0,  7, 63,  5, 1};
    vecs[5] = '{1,   1, 188,  0, 62,  0,  4,  1,  1, 0};
    vecs[6] = '{0, 127, 188,  0,  1, 62,  0,  0, 63, 1};
    vecs[7] = '{63, 63, 191, 63,  0,  0,  0, 63, 63, 0};

    repeat (3) @(negedge clk40);
    chk("reset_outputs", outs_packed(), 0);
    rst = 1'b0;
    @(negedge clk40);
    chk("post_reset_idle", outs_packed(), 0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // tap_reset returns both taps to zero
    @(negedge clk40); tap_reset = 1'b1;
    @(negedge clk40); tap_reset = 1'b0;
    chk("tap_reset_taps", int'({clk_tap, data_tap}), 0);

    // Retarget mid-walk: up toward 20, then back to 2 after four pulses
    @(negedge clk40);
    load_strb = 1'b1; clk_target = TW'(20); data_target = TW'(0);
    c4 = -1; ce_cnt = 0;
    for (int cyc = 1; cyc <= BUDGET && c4 < 0; cyc++) begin
      @(negedge clk40); load_strb = 1'b0;
      if (clk_ce) ce_cnt++;
      if (ce_cnt == 4) c4 = cyc;
    end
    chk("retarget_4th_pulse_cycle", c4, 11);
    chk("retarget_tap_at_4", int'(clk_tap), 4);
    load_strb = 1'b1; clk_target = TW'(2); data_target = TW'(0);
    cnt_dn = 0; cnt_up = 0; dones = 0; done_at = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk40); load_strb = 1'b0;
      if (clk_ce) begin if (clk_inc) cnt_up++; else cnt_dn++; end
      if (done_strb) begin dones++; if (done_at < 0) done_at = k; end
    end
    chk("retarget_down_steps", cnt_dn, 2);
    chk("retarget_up_steps", cnt_up, 0);
    chk("retarget_done_count", dones, 1);
    chk("retarget_done_cycle", done_at, 9);
    chk("retarget_final_tap", int'(clk_tap), 2);

    // Load landing on the settle slot suppresses done and keeps walking
    @(negedge clk40);
    load_strb = 1'b1; clk_target = TW'(4); data_target = TW'(0);
    dones = 0; done_at = -1; busy_lo = 0; hit = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk40);
      if (done_strb) begin dones++; if (done_at < 0) done_at = cyc; end
      if (cyc <= 11 && !busy) busy_lo++;
      if (cyc == 8) hit = clk_ce && clk_inc && (clk_tap == TW'(5));
      load_strb = (cyc == 7);
      if (cyc == 7) clk_target = TW'(5);
    end
    chk("settle_load_done_count", dones, 1);
    chk("settle_load_done_cycle", done_at, 11);
    chk("settle_load_busy_gap", busy_lo, 0);
    chk("settle_load_step8", int'(hit), 1);

    // tap_reset during a decision cycle, with a simultaneous over-range load
    @(negedge clk40);
    load_strb = 1'b1; clk_target = TW'(30); data_target = TW'(30);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk40); load_strb = 1'b0;
    end
    tap_reset = 1'b1; load_strb = 1'b1; clk_target = TW'(100); data_target = TW'(100);
    @(negedge clk40);
    tap_reset = 1'b0; load_strb = 1'b0;
    chk("tap_reset_outputs", outs_packed(), 0);
    ce_cnt = 0; dones = 0; busy_lo = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk40);
      if (clk_ce || data_ce) ce_cnt++;
      if (done_strb) dones++;
      if (busy) busy_lo++;
    end
    chk("tap_reset_no_ce", ce_cnt, 0);
    chk("tap_reset_no_done", dones, 0);
    chk("tap_reset_stays_idle", busy_lo, 0);

    // Async rst mid-walk clears outputs before any clock edge
    @(negedge clk40);
    load_strb = 1'b1; clk_target = TW'(30); data_target = TW'(100);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk40); load_strb = 1'b0;
    end
    chk("pre_rst_walk", int'({clk_ce, saturated, clk_tap, data_tap}), int'({1'b1, 1'b1, TW'(2), TW'(2)}));
    #1 rst = 1'b1;
    #1 chk("async_rst_outputs", outs_packed(), 0);
    chk("async_rst_no_edge", int'(clk40), 0);
    @(negedge clk40); rst = 1'b0;

    rand_phase(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
